// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-enabled data memory.
// Holds the clear/ready state type, lane-count helpers and the byte-mask legality check.
package dm_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_t;

  // Widest lane mask the legality check supports (512-bit words).
  localparam int MAX_NB = 64;

  function automatic int dm_nb(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits inside a word, i.e. log2 of the lane count.
  function automatic int dm_lane_bits(input int data_w);
    int nb;
    int lb;
    nb = data_w / 8;
    lb = 0;
    while ((1 << lb) < nb) lb++;
    return lb;
  endfunction

  // A mask is legal when it covers the whole word, or when it is a naturally
  // aligned run of 2^k lanes (smaller than the word) that begins at start.
  function automatic logic dm_mask_legal(input logic [MAX_NB-1:0] be, input int nb,
                                         input int start);
    logic [MAX_NB-1:0] full;
    logic [MAX_NB-1:0] grp;
    logic              ok;
    int                size;
    full = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      if (i < nb) full[i] = 1'b1;
    end
    ok = (be == full);
    for (int k = 0; k < 6; k++) begin
      size = 1 << k;
      if ((size < nb) && ((start & (size - 1)) == 0) && (start + size <= nb)) begin
        grp = '0;
        for (int i = 0; i < MAX_NB; i++) begin
          if ((i >= start) && (i < start + size)) grp[i] = 1'b1;
        end
        if (be == grp) ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/dm_be_check.sv
// Combinational access checker: mask legality plus address range.
// start_lane is the lane that receives byte 0 of the right-aligned store data.
module dm_be_check
  import dm_pkg::*;
#(
  parameter int NB = 4,
  parameter int LW = 2,
  parameter int RW = 26
) (
  input  logic [NB-1:0] be,
  input  logic [LW-1:0] addr_lo,
  input  logic [RW-1:0] addr_hi,
  output logic          legal,
  output logic [LW-1:0] start_lane
);

  logic [MAX_NB-1:0] be_ext;
  logic              mask_ok;
  logic              in_range;

  always_comb begin
    be_ext           = '0;
    be_ext[NB-1:0]   = be;
    mask_ok          = dm_mask_legal(be_ext, NB, int'(addr_lo));
    in_range         = (addr_hi == '0);
    legal            = mask_ok && in_range;
    // A full-word mask is legal regardless of the low address bits and always starts at lane 0.
    start_lane       = (be == {NB{1'b1}}) ? '0 : addr_lo;
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-enabled data memory, zero-filled by a clear sweep after reset, 1-cycle load latency.
// Optional store trace is compiled in with DM_TRACE_EN.
module data_mem_be
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [DATA_W/8-1:0]    req_be,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [31:0]            req_pc,
  output logic                   ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   exc_adel,
  output logic                   exc_ades
);

  localparam int NB    = dm_nb(DATA_W);
  localparam int LW    = dm_lane_bits(DATA_W);
  localparam int RW    = 32 - ADDR_W - LW;
  localparam int DEPTH = 2 ** ADDR_W;

  dm_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              clearing;
  logic              accept;
  logic              is_store;
  logic              legal;
  logic              commit;
  logic [LW-1:0]     start_lane;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] wdata_shift;

  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_reg;

  logic              rd_valid_reg;
  logic              exc_adel_reg;
  logic              exc_ades_reg;

  dm_be_check #(
    .NB(NB),
    .LW(LW),
    .RW(RW)
  ) u_be_check (
    .be         (req_be),
    .addr_lo    (req_addr[LW-1:0]),
    .addr_hi    (req_addr[31:LW+ADDR_W]),
    .legal      (legal),
    .start_lane (start_lane)
  );

  // ---------------- clear sweep FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = READY;
          cnt_next   = '0;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- request decode ----------------
  assign clearing    = (state_reg == CLEAR);
  assign ready       = (state_reg == READY) && !reset;
  assign accept      = req_valid && ready;
  // Only a definite 1 counts as a store; X/Z falls through to the load path.
  assign is_store    = (req_we === 1'b1);
  assign commit      = accept && is_store && legal;
  assign word_addr   = req_addr[LW +: ADDR_W];
  assign wdata_shift = req_wdata << (int'(start_lane) * 8);
  assign mem_addr    = clearing ? cnt_reg : word_addr;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign mem_we[gi]             = clearing || (commit && req_be[gi]);
    assign mem_wdata[gi*8 +: 8]   = clearing ? 8'h00 : wdata_shift[gi*8 +: 8];
  end

  // Single-port storage with per-lane write enables and a registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
    rd_word_reg <= mem[mem_addr];
  end

  // ---------------- response pipeline ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      exc_adel_reg <= 1'b0;
      exc_ades_reg <= 1'b0;
    end else begin
      rd_valid_reg <= accept && !is_store;
      exc_adel_reg <= accept && !is_store && !legal;
      exc_ades_reg <= accept && is_store && !legal;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after its edge.
  assign rd_valid = rd_valid_reg && !reset;
  assign exc_adel = exc_adel_reg && !reset;
  assign exc_ades = exc_ades_reg && !reset;
  assign rd_data  = (rd_valid && !exc_adel_reg) ? rd_word_reg : '0;

`ifdef DM_TRACE_EN
  logic [DATA_W-1:0] trace_word;

  always_comb begin
    trace_word = mem[word_addr];
    for (int i = 0; i < NB; i++) begin
      if (req_be[i]) trace_word[i*8 +: 8] = wdata_shift[i*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (commit) begin
      $display("%0t@%h: *%h <= %h", $time, req_pc - 32'd4,
               {req_addr[31:LW], {LW{1'b0}}}, trace_word);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning word-address bits; depth is 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width; it must be a multiple of 8, and NB = DATA_W/8.
REQ-003 The block SHALL have port clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset; this is the only reset, on the single clock clk.
REQ-005 The block SHALL have port req_valid  in  1  access request this cycle.
REQ-006 The block SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 The block SHALL have port req_be  in  NB  byte-lane mask.
REQ-008 The block SHALL have port req_addr  in  32  byte address.
REQ-009 The block SHALL have port req_wdata  in  DATA_W  store data, right-aligned (lane 0 holds the byte or half).
REQ-010 The block SHALL have port req_pc  in  32  PC of the issuing instruction, used by trace only.
REQ-011 The block SHALL have port ready  out  1  block accepts requests.
REQ-012 The block SHALL have port rd_valid  out  1  load response valid.
REQ-013 The block SHALL have port rd_data  out  DATA_W  full addressed word.
REQ-014 The block SHALL have port exc_adel  out  1  load address error.
REQ-015 The block SHALL have port exc_ades  out  1  store address error.

Function
REQ-016 The block SHALL implement a two-state FSM: CLEAR, where a counter writes 0 to word[cnt] each cycle, and READY.
REQ-017 The FSM SHALL leave CLEAR for READY on the cycle after cnt = 2**ADDR_W-1; CLEAR lasts exactly 2**ADDR_W cycles, and ready=1 only in READY.
REQ-018 A request SHALL be accepted only when req_valid & ready; requests while ready=0 are dropped with no response and no exception.
REQ-019 A mask SHALL be legal iff it is all-ones, or an aligned contiguous group of 2^k lanes (k < log2 NB) whose start lane equals req_addr[log2 NB-1:0].
REQ-020 For NB=4, the legal masks SHALL be 1111, 0011, 1100, 0001, 0010, 0100 and 1000.
REQ-021 A request SHALL be in range iff req_addr[31:ADDR_W+log2 NB] == 0.
REQ-022 An accepted legal, in-range store SHALL write each enabled lane i with req_wdata lane (i - start lane) at the accepting edge; other lanes are unchanged.
REQ-023 An illegal or out-of-range store SHALL write nothing and SHALL pulse exc_ades for one cycle, in the cycle after acceptance.
REQ-024 An accepted load SHALL give rd_valid=1 for one cycle, exactly 1 cycle after acceptance, with rd_data = the full addressed word at the accepting edge.
REQ-025 An illegal or out-of-range load SHALL also give rd_valid=1, with rd_data=0 and exc_adel=1, in that same cycle.
REQ-026 A load in cycle N+1 to a word stored in cycle N SHALL return the post-store value.
REQ-027 Back-to-back requests SHALL be accepted every cycle with no bubbles.
REQ-028 An undefined req_we (X/Z) SHALL be treated as a load.

Reset
REQ-029 While reset=1, and after reset is released, the block SHALL be in CLEAR with cnt=0, ready=0, rd_valid=0, rd_data=0, exc_adel=0 and exc_ades=0.
REQ-030 A reset asserted during CLEAR SHALL restart cnt at 0.
REQ-031 A reset asserted during READY SHALL discard any pending response.
REQ-032 Memory contents SHALL be all zero when ready first rises.

Configuration
REQ-033 With DM_TRACE_EN defined, each committed store SHALL print "<time>@<req_pc-4 hex>: *<word-aligned byte addr hex> <= <merged full word hex>".
REQ-034 The merged word in the trace SHALL be the word value after the store, and is printed at the committing edge.
REQ-035 No trace SHALL be printed during reset, CLEAR, or for faulting stores.
REQ-036 Without DM_TRACE_EN, the block SHALL contain no trace logic, and its behaviour SHALL otherwise be identical.

Structure
REQ-037 Package dm_pkg SHALL hold the FSM state typedef (CLEAR, READY), the NB/lane-offset helper function, and the mask-legality function.
REQ-038 Sub-module dm_be_check (combinational: be, addr low bits, range bits -> legal, start_lane) SHALL be instantiated once.
REQ-039 Storage SHALL be a single-port DATA_W x 2**ADDR_W array.

Verification
REQ-040 The bench SHALL cover: reset 1 cycle, ADDR_W=4 -> ready=0 for exactly 16 cycles, then 1; all words read 0.
REQ-041 The bench SHALL cover: sw 0xDEADBEEF @0x8, then lw @0x8 next cycle -> rd_valid one cycle later, rd_data=0xDEADBEEF.
REQ-042 The bench SHALL cover: sb wdata=0x000000AA, be=0100 @0xA, then lw @0x8 -> 0xDEAABEEF.
REQ-043 The bench SHALL cover: sh be=1100 @0x9 -> exc_ades=1 one cycle later, memory unchanged.
REQ-044 The bench SHALL cover: lw @0x40 with ADDR_W=4 -> exc_adel=1, rd_data=0.
REQ-045 The bench SHALL cover: reset mid-CLEAR at cnt=7 -> CLEAR restarts and ready rises 16 cycles after reset drops; with DM_TRACE_EN, the REQ-041 store prints "...@<pc-4>: *00000008 <= deadbeef".
